// File: rtl/jzjpcc_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Combinational fetch lookup, decode-stage update and mispredict redirect.
module jzjpcc_branch_predictor #(
    parameter int          PC_MAX_B     = 31,
    parameter int          INDEX_BITS   = 6,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PC_MAX_B:2] currentPC_fetch,
    output logic              predictTaken_fetch,
    output logic [PC_MAX_B:2] predictedPC_fetch,
    input  logic              resolveValid_decode,
    input  logic              isConditional_decode,
    input  logic              actualTaken_decode,
    input  logic [PC_MAX_B:2] actualTarget_decode,
    input  logic [PC_MAX_B:2] currentPC_decode,
    input  logic              predictedTaken_decode,
    input  logic [PC_MAX_B:2] predictedPC_decode,
    input  logic              stall,
    output logic              mispredict,
    output logic [PC_MAX_B:2] correctPC,
    output logic [15:0]       mispredictCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;

    typedef logic [PC_MAX_B:2]      pc_t;
    typedef logic [PC_MAX_B:TAG_LO] tag_t;
    typedef logic [INDEX_BITS-1:0]  idx_t;

    localparam pc_t PC_ONE = pc_t'(1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] uncond_q, uncond_d;
    tag_t               tag_q    [ENTRIES];
    tag_t               tag_d    [ENTRIES];
    pc_t                target_q [ENTRIES];
    pc_t                target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [15:0]        count_q, count_d;

    idx_t f_idx, d_idx;
    tag_t f_tag, d_tag;
    logic f_hit, d_hit, update;

    assign f_idx = currentPC_fetch[INDEX_BITS+1:2];
    assign f_tag = currentPC_fetch[PC_MAX_B:TAG_LO];
    assign d_idx = currentPC_decode[INDEX_BITS+1:2];
    assign d_tag = currentPC_decode[PC_MAX_B:TAG_LO];

    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign d_hit  = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
    assign update = resolveValid_decode && !stall;

    // Lookup reads registered state only, so same-cycle updates are not seen
    assign predictTaken_fetch = f_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
    assign predictedPC_fetch  = predictTaken_fetch ? target_q[f_idx]
                                                   : currentPC_fetch + PC_ONE;

    assign mispredict = resolveValid_decode &&
                        ((predictedTaken_decode != actualTaken_decode) ||
                         (actualTaken_decode &&
                          (predictedPC_decode != actualTarget_decode)));
    assign correctPC  = actualTaken_decode ? actualTarget_decode
                                           : currentPC_decode + PC_ONE;
    assign mispredictCount = count_q;

    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        count_d  = count_q;
        if (mispredict && !stall && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
        if (update) begin
            if (d_hit) begin
                if (isConditional_decode) begin
                    uncond_d[d_idx] = 1'b0;
                    if (actualTaken_decode)
                        ctr_d[d_idx] = (ctr_q[d_idx] == 2'b11) ? 2'b11
                                                               : ctr_q[d_idx] + 2'b01;
                    else
                        ctr_d[d_idx] = (ctr_q[d_idx] == 2'b00) ? 2'b00
                                                               : ctr_q[d_idx] - 2'b01;
                end else begin
                    uncond_d[d_idx] = 1'b1;
                    ctr_d[d_idx]    = 2'b11;
                end
                if (actualTaken_decode)
                    target_d[d_idx] = actualTarget_decode;
            end else if (actualTaken_decode) begin
                valid_d[d_idx]  = 1'b1;
                tag_d[d_idx]    = d_tag;
                target_d[d_idx] = actualTarget_decode;
                uncond_d[d_idx] = !isConditional_decode;
                ctr_d[d_idx]    = isConditional_decode ? 2'b10 : 2'b11;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            uncond_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= COUNTER_INIT;
            end
        end else begin
            valid_q  <= valid_d;
            uncond_q <= uncond_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_jzjpcc_branch_predictor.sv
// Randomized bench for jzjpcc_branch_predictor against an array-based model.
// Directed scenarios first, then random traffic, then counter saturation.
module tb_jzjpcc_branch_predictor;

    localparam int unsigned PC_MOD = 32'h4000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] currentPC_fetch = '0;
    logic        predictTaken_fetch;
    logic [31:2] predictedPC_fetch;
    logic        resolveValid_decode = 1'b0;
    logic        isConditional_decode = 1'b0;
    logic        actualTaken_decode = 1'b0;
    logic [31:2] actualTarget_decode = '0;
    logic [31:2] currentPC_decode = '0;
    logic        predictedTaken_decode = 1'b0;
    logic [31:2] predictedPC_decode = '0;
    logic        stall = 1'b0;
    logic        mispredict;
    logic [31:2] correctPC;
    logic [15:0] mispredictCount;

    int total = 0;
    int bad   = 0;

    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    bit          m_unc   [64];
    int          m_ctr   [64];
    int          m_count;

    jzjpcc_branch_predictor dut (
        .clock                 (clock),
        .reset                 (reset),
        .currentPC_fetch       (currentPC_fetch),
        .predictTaken_fetch    (predictTaken_fetch),
        .predictedPC_fetch     (predictedPC_fetch),
        .resolveValid_decode   (resolveValid_decode),
        .isConditional_decode  (isConditional_decode),
        .actualTaken_decode    (actualTaken_decode),
        .actualTarget_decode   (actualTarget_decode),
        .currentPC_decode      (currentPC_decode),
        .predictedTaken_decode (predictedTaken_decode),
        .predictedPC_decode    (predictedPC_decode),
        .stall                 (stall),
        .mispredict            (mispredict),
        .correctPC             (correctPC),
        .mispredictCount       (mispredictCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_count = 0;
    endfunction

    function automatic void model_fetch(input int unsigned pc, output bit tk,
                                        output int unsigned nxt);
        int unsigned i = pc % 64;
        bit hit = m_valid[i] && (m_tag[i] == pc / 64);
        tk  = hit && (m_unc[i] || m_ctr[i] >= 2);
        nxt = tk ? m_tgt[i] : (pc + 1) % PC_MOD;
    endfunction

    function automatic bit model_mp(input bit rv, input bit tk,
                                    input int unsigned tgt, input bit ptk,
                                    input int unsigned ppc);
        return rv && ((ptk != tk) || (tk && ppc != tgt));
    endfunction

    function automatic void model_update(input bit rv, input bit cond,
                                         input bit tk, input int unsigned tgt,
                                         input int unsigned dpc, input bit ptk,
                                         input int unsigned ppc, input bit st);
        int unsigned i = dpc % 64;
        if (!rv || st) return;
        if (model_mp(rv, tk, tgt, ptk, ppc) && m_count < 65535)
            m_count++;
        if (m_valid[i] && m_tag[i] == dpc / 64) begin
            if (cond) begin
                m_unc[i] = 0;
                m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
            end else begin
                m_unc[i] = 1;
                m_ctr[i] = 3;
            end
            if (tk) m_tgt[i] = tgt;
        end else if (tk) begin
            m_valid[i] = 1;
            m_tag[i]   = dpc / 64;
            m_tgt[i]   = tgt;
            m_unc[i]   = !cond;
            m_ctr[i]   = cond ? 2 : 3;
        end
    endfunction

    task automatic step(input bit rv, input bit cond, input bit tk,
                        input int unsigned tgt, input int unsigned dpc,
                        input bit ptk, input int unsigned ppc, input bit st,
                        input int unsigned fpc);
        bit          etk;
        int unsigned enx;
        resolveValid_decode   = rv;
        isConditional_decode  = cond;
        actualTaken_decode    = tk;
        actualTarget_decode   = tgt[29:0];
        currentPC_decode      = dpc[29:0];
        predictedTaken_decode = ptk;
        predictedPC_decode    = ppc[29:0];
        stall                 = st;
        currentPC_fetch       = fpc[29:0];
        #1;
        model_fetch(fpc, etk, enx);
        chk("predict_taken", predictTaken_fetch, etk);
        chk("predicted_pc", predictedPC_fetch, enx);
        chk("mispredict", mispredict, model_mp(rv, tk, tgt, ptk, ppc));
        chk("correct_pc", correctPC, tk ? tgt : (dpc + 1) % PC_MOD);
        chk("count", mispredictCount, m_count);
        @(posedge clock);
        model_update(rv, cond, tk, tgt, dpc, ptk, ppc, st);
        @(negedge clock);
    endtask

    task automatic idle(input int unsigned fpc);
        step(0, 0, 0, 0, 0, 0, 0, 0, fpc);
    endtask

    initial begin
        int unsigned tags [3];
        int unsigned idxs [4];
        model_reset();
        currentPC_fetch = 30'h40;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_taken", predictTaken_fetch, 0);
        chk("rst_next", predictedPC_fetch, 32'h41);
        chk("rst_count", mispredictCount, 0);
        @(negedge clock);
        reset = 1'b1;

        idle(32'h40);
        step(1, 1, 1, 32'h20, 32'h40, 0, 32'h41, 0, 32'h40);
        idle(32'h40);
        chk("cnt_after_first", mispredictCount, 16'd1);
        step(1, 1, 0, 32'h20, 32'h40, 1, 32'h20, 0, 32'h40);
        idle(32'h40);
        step(1, 1, 0, 32'h20, 32'h40, 0, 32'h41, 0, 32'h40);
        idle(32'h40);
        step(1, 1, 1, 32'h24, 32'h40, 0, 32'h41, 0, 32'h40);
        idle(32'h40);

        step(1, 0, 1, 32'h100, 32'h80, 0, 32'h81, 0, 32'h80);
        idle(32'hC0);
        idle(32'h80);
        chk("jal_hit", predictedPC_fetch, 32'h100);

        idle(32'h3FFF_FFFF);
        step(1, 1, 1, 32'h300, 32'hC0, 0, 32'hC1, 1, 32'hC0);
        idle(32'hC0);

        resolveValid_decode = 1'b1;
        isConditional_decode = 1'b0;
        actualTaken_decode = 1'b1;
        actualTarget_decode = 30'h77;
        currentPC_decode = 30'h10;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle(32'h10);

        tags = '{32'h0, 32'h1, 32'hFF_FFFF};
        idxs = '{0, 5, 17, 63};
        for (int n = 0; n < 3000; n++) begin
            int unsigned dpc, fpc, tgt, ppc;
            bit          ptk, rv, cond, tk, st;
            dpc  = tags[$urandom_range(2)] * 64 + idxs[$urandom_range(3)];
            fpc  = ($urandom_range(1) == 1) ? dpc
                 : tags[$urandom_range(2)] * 64 + idxs[$urandom_range(3)];
            tgt  = $urandom_range(7) * 16;
            rv   = $urandom_range(3) != 0;
            cond = $urandom_range(3) != 0;
            tk   = $urandom_range(1) == 1;
            st   = $urandom_range(7) == 0;
            if ($urandom_range(1) == 1) model_fetch(dpc, ptk, ppc);
            else begin
                ptk = $urandom_range(1) == 1;
                ppc = $urandom_range(7) * 16;
            end
            step(rv, cond, tk, tgt, dpc, ptk, ppc, st, fpc);
        end

        resolveValid_decode = 1'b1;
        isConditional_decode = 1'b1;
        actualTaken_decode = 1'b1;
        actualTarget_decode = 30'h55;
        currentPC_decode = 30'h33;
        predictedTaken_decode = 1'b0;
        predictedPC_decode = 30'h34;
        stall = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            @(posedge clock);
            model_update(1, 1, 1, 32'h55, 32'h33, 0, 32'h34, 0);
        end
        @(negedge clock);
        #1;
        chk("sat_model", mispredictCount, m_count);
        chk("sat_const", mispredictCount, 16'hFFFF);
        reset = 1'b0;
        #1;
        chk("async_clear", mispredictCount, 0);
        currentPC_fetch = 30'h33;
        #1;
        chk("async_miss", predictTaken_fetch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
